// File: rtl/xintf_mailbox_engine.sv
// Zynq<->DSP mailbox over the XINTF dual-port BRAM: snapshot write frames, atomic read commits.
// Optional read checksum: define XINTF_RD_CHECKSUM_EN to reject frames whose last word mismatches.
module xintf_mailbox_engine #(
  parameter int ADDR_W  = 9,
  parameter int W_BASE  = 8,
  parameter int W_WORDS = 40,
  parameter int R_BASE  = 129,
  parameter int R_WORDS = 46,
  parameter int RAM_LAT = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [16*W_WORDS-1:0]   i_w_data,
  input  logic                    i_w_ready,
  output logic                    o_w_valid,
  input  logic                    i_r_valid,
  output logic [ADDR_W-1:0]       o_w_ram_addr,
  output logic [15:0]             o_w_ram_din,
  output logic                    o_w_ram_ce,
  input  logic [15:0]             i_r_ram_dout,
  output logic [ADDR_W-1:0]       o_r_ram_addr,
  output logic                    o_r_ram_ce,
  output logic [16*R_WORDS-1:0]   o_r_data,
  output logic                    o_r_update,
  output logic                    o_r_err,
  output logic [1:0]              o_w_state,
  output logic [1:0]              o_r_state,
  output logic [15:0]             o_frame_cnt
);

  localparam int KW = $clog2(W_WORDS);
  localparam int KR = $clog2(R_WORDS);

  if (W_BASE + W_WORDS > (1 << ADDR_W) || W_WORDS < 2) begin : g_w_chk
    $error("write window must hold >=2 words and fit in the DPBRAM");
  end
  if (R_BASE + R_WORDS > (1 << ADDR_W) || R_WORDS < 2) begin : g_r_chk
    $error("read window must hold >=2 words and fit in the DPBRAM");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_lat_chk
    $error("RAM_LAT must be 1..3");
  end

  // Write handshake: o_w_valid stays high for the whole HOLD state; the frame is
  // handed over on the first cycle with o_w_valid && i_w_ready. i_w_ready is ignored elsewhere.
  typedef enum logic [1:0] {W_IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2, W_DONE = 2'd3} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_SETUP = 2'd1, READ = 2'd2, R_DONE = 2'd3} r_state_t;

  w_state_t              w_state;
  logic [KW-1:0]         w_k;
  logic [KW-1:0]         w_k_nxt;
  logic [16*W_WORDS-1:0] w_snap;

  assign w_k_nxt   = w_k + KW'(1);
  assign o_w_valid = (w_state == HOLD);
  assign o_w_state = w_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state      <= W_IDLE;
      w_k          <= '0;
      w_snap       <= '0;
      o_w_ram_ce   <= 1'b0;
      o_w_ram_addr <= '0;
      o_w_ram_din  <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (i_en) begin
          w_snap       <= i_w_data;
          w_k          <= '0;
          o_w_ram_ce   <= 1'b1;
          o_w_ram_addr <= ADDR_W'(W_BASE);
          o_w_ram_din  <= i_w_data[15:0];
          w_state      <= WRITE;
        end
        WRITE: begin
          if (w_k == KW'(W_WORDS - 1)) begin
            o_w_ram_ce   <= 1'b0;
            o_w_ram_addr <= '0;
            o_w_ram_din  <= '0;
            w_state      <= HOLD;
          end else begin
            w_k          <= w_k_nxt;
            o_w_ram_addr <= ADDR_W'(W_BASE) + ADDR_W'(w_k_nxt);
            o_w_ram_din  <= w_snap[16*int'(w_k_nxt) +: 16];
          end
        end
        HOLD:    if (i_w_ready) w_state <= W_DONE;
        W_DONE:  w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  r_state_t              r_state;
  logic [KR-1:0]         r_ik;
  logic [KR-1:0]         r_ik_nxt;
  logic [16*R_WORDS-1:0] shadow;
  logic [RAM_LAT-1:0]    pv;
  logic [KR-1:0]         pidx [RAM_LAT];
  logic                  r_push;
  logic                  csum_ok;

  assign r_ik_nxt  = r_ik + KR'(1);
  assign r_push    = (r_state == READ) && o_r_ram_ce;
  assign o_r_state = r_state;

`ifdef XINTF_RD_CHECKSUM_EN
  logic [15:0] r_sum;
  always_comb begin
    r_sum = '0;
    for (int i = 0; i < R_WORDS - 1; i++) r_sum = r_sum + shadow[16*i +: 16];
  end
  assign csum_ok = (r_sum == shadow[16*(R_WORDS-1) +: 16]);
`else
  assign csum_ok = 1'b1;
`endif

  // pv/pidx delay each issued word index by RAM_LAT cycles so it lines up with its dout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= R_IDLE;
      r_ik         <= '0;
      o_r_ram_ce   <= 1'b0;
      o_r_ram_addr <= '0;
      shadow       <= '0;
      o_r_data     <= '0;
      o_r_update   <= 1'b0;
      o_r_err      <= 1'b0;
      o_frame_cnt  <= '0;
      pv           <= '0;
      for (int i = 0; i < RAM_LAT; i++) pidx[i] <= '0;
    end else begin
      o_r_update <= 1'b0;
      o_r_err    <= 1'b0;
      pv[0]      <= r_push;
      pidx[0]    <= r_ik;
      for (int i = 1; i < RAM_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      case (r_state)
        R_IDLE: if (i_en) begin
          o_r_ram_ce   <= 1'b1;
          o_r_ram_addr <= ADDR_W'(R_BASE);
          r_ik         <= '0;
          r_state      <= R_SETUP;
        end
        R_SETUP: if (i_r_valid) r_state <= READ;
        READ: begin
          if (o_r_ram_ce) begin
            if (r_ik == KR'(R_WORDS - 1)) begin
              o_r_ram_ce   <= 1'b0;
              o_r_ram_addr <= '0;
            end else begin
              r_ik         <= r_ik_nxt;
              o_r_ram_addr <= ADDR_W'(R_BASE) + ADDR_W'(r_ik_nxt);
            end
          end
          if (pv[RAM_LAT-1]) begin
            shadow[16*int'(pidx[RAM_LAT-1]) +: 16] <= i_r_ram_dout;
            if (pidx[RAM_LAT-1] == KR'(R_WORDS - 1)) r_state <= R_DONE;
          end
        end
        R_DONE: begin
          if (csum_ok) begin
            o_r_data    <= shadow;
            o_r_update  <= 1'b1;
            o_frame_cnt <= o_frame_cnt + 16'd1;
          end else begin
            o_r_err <= 1'b1;
          end
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xintf_mailbox_engine.sv
// Scoreboard bench for xintf_mailbox_engine; RAM_LAT=1 and RAM_LAT=3 instances share stimulus.
module tb_xintf_mailbox_engine;

  localparam int ADDR_W  = 9;
  localparam int W_BASE  = 8;
  localparam int W_WORDS = 40;
  localparam int R_BASE  = 129;
  localparam int R_WORDS = 46;
  localparam int WD = 16 * W_WORDS;
  localparam int RD = 16 * R_WORDS;
  localparam int E  = RD + 17;
`ifdef XINTF_RD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, w_ready, r_valid;
  logic [WD-1:0] w_data;

  logic u1_w_valid, u1_w_ce, u1_r_ce, u1_r_upd, u1_r_err;
  logic [ADDR_W-1:0] u1_w_addr, u1_r_addr;
  logic [15:0] u1_w_din, u1_cnt, dout1;
  logic [RD-1:0] u1_r_data;
  logic [1:0] u1_w_state, u1_r_state;

  logic u3_w_valid, u3_w_ce, u3_r_ce, u3_r_upd, u3_r_err;
  logic [ADDR_W-1:0] u3_w_addr, u3_r_addr;
  logic [15:0] u3_w_din, u3_cnt, dout3;
  logic [RD-1:0] u3_r_data;
  logic [1:0] u3_w_state, u3_r_state;

  logic [15:0] mem [512];
  logic [ADDR_W-1:0] a1_d;
  logic [ADDR_W-1:0] a3_d [3];

  int n_checks = 0;
  int n_fail = 0;
  bit w_chk = 1'b0;
  logic [24:0] exp_w_q[$];
  logic [24:0] exp_beat;
  logic [E-1:0] exp_r1_q[$];
  logic [E-1:0] exp_r3_q[$];
  logic [15:0] exp_cnt;
  logic [RD-1:0] exp_data;

  always #5 clk = ~clk;

  xintf_mailbox_engine #(.ADDR_W(ADDR_W), .W_BASE(W_BASE), .W_WORDS(W_WORDS), .R_BASE(R_BASE),
                         .R_WORDS(R_WORDS), .RAM_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_w_data(w_data), .i_w_ready(w_ready),
    .o_w_valid(u1_w_valid), .i_r_valid(r_valid), .o_w_ram_addr(u1_w_addr), .o_w_ram_din(u1_w_din),
    .o_w_ram_ce(u1_w_ce), .i_r_ram_dout(dout1), .o_r_ram_addr(u1_r_addr), .o_r_ram_ce(u1_r_ce),
    .o_r_data(u1_r_data), .o_r_update(u1_r_upd), .o_r_err(u1_r_err), .o_w_state(u1_w_state),
    .o_r_state(u1_r_state), .o_frame_cnt(u1_cnt));

  xintf_mailbox_engine #(.ADDR_W(ADDR_W), .W_BASE(W_BASE), .W_WORDS(W_WORDS), .R_BASE(R_BASE),
                         .R_WORDS(R_WORDS), .RAM_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_w_data(w_data), .i_w_ready(w_ready),
    .o_w_valid(u3_w_valid), .i_r_valid(r_valid), .o_w_ram_addr(u3_w_addr), .o_w_ram_din(u3_w_din),
    .o_w_ram_ce(u3_w_ce), .i_r_ram_dout(dout3), .o_r_ram_addr(u3_r_addr), .o_r_ram_ce(u3_r_ce),
    .o_r_data(u3_r_data), .o_r_update(u3_r_upd), .o_r_err(u3_r_err), .o_w_state(u3_w_state),
    .o_r_state(u3_r_state), .o_frame_cnt(u3_cnt));

  // DPBRAM read ports: dout follows the address by 1 and 3 cycles respectively.
  always @(posedge clk) begin
    a1_d    <= u1_r_addr;
    a3_d[0] <= u3_r_addr;
    a3_d[1] <= a3_d[0];
    a3_d[2] <= a3_d[1];
  end
  assign dout1 = mem[a1_d];
  assign dout3 = mem[a3_d[2]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input logic [RD-1:0] act, input logic [RD-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got w0=%h w45=%h want w0=%h w45=%h", nm, act[15:0], act[RD-1 -: 16],
               exp[15:0], exp[RD-1 -: 16]);
    end
  endtask

  task automatic cmp_read(input string nm, input bit have, input logic [E-1:0] e, input logic upd,
                          input logic err, input logic [RD-1:0] d, input logic [15:0] c);
    n_checks++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s read_event: unexpected upd=%0b err=%0b", nm, upd, err);
    end else if (upd !== !e[E-1] || err !== e[E-1] || c !== e[RD +: 16] || d !== e[RD-1:0]) begin
      n_fail++;
      $display("FAIL %s read_frame: got upd=%0b err=%0b cnt=%h w0=%h w45=%h, want upd=%0b err=%0b cnt=%h w0=%h w45=%h",
               nm, upd, err, c, d[15:0], d[RD-1 -: 16], !e[E-1], e[E-1], e[RD +: 16],
               e[15:0], e[RD-1 -: 16]);
    end
  endtask

  // Write-side monitor (RAM_LAT=1 instance): each ce beat must match the head of the queue.
  always @(negedge clk) begin
    if (w_chk && u1_w_ce) begin
      n_checks++;
      if (exp_w_q.size() == 0) begin
        n_fail++;
        $display("FAIL w_beat: unexpected addr=%0d din=%h", u1_w_addr, u1_w_din);
      end else begin
        exp_beat = exp_w_q.pop_front();
        if ({u1_w_addr, u1_w_din} !== exp_beat) begin
          n_fail++;
          $display("FAIL w_beat: got addr=%0d din=%h want addr=%0d din=%h", u1_w_addr, u1_w_din,
                   exp_beat[24:16], exp_beat[15:0]);
        end
      end
    end else if (w_chk) begin
      check("w_addr_idle", 32'(u1_w_addr), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (u1_r_upd || u1_r_err) begin
      if (exp_r1_q.size() > 0) cmp_read("lat1", 1'b1, exp_r1_q.pop_front(), u1_r_upd, u1_r_err, u1_r_data, u1_cnt);
      else cmp_read("lat1", 1'b0, '0, u1_r_upd, u1_r_err, u1_r_data, u1_cnt);
    end
  end

  always @(negedge clk) begin
    if (u3_r_upd || u3_r_err) begin
      if (exp_r3_q.size() > 0) cmp_read("lat3", 1'b1, exp_r3_q.pop_front(), u3_r_upd, u3_r_err, u3_r_data, u3_cnt);
      else cmp_read("lat3", 1'b0, '0, u3_r_upd, u3_r_err, u3_r_data, u3_cnt);
    end
  end

  task automatic set_wdata(input logic [15:0] base, input bit push);
    for (int k = 0; k < W_WORDS; k++) begin
      w_data[16*k +: 16] = base + 16'(k);
      if (push) exp_w_q.push_back({9'(W_BASE + k), 16'(base + 16'(k))});
    end
  endtask

  // Reference model of one read frame from the current RAM contents.
  task automatic push_read();
    logic [RD-1:0] f;
    logic [15:0] s;
    bit ok;
    s = '0;
    for (int k = 0; k < R_WORDS; k++) f[16*k +: 16] = mem[R_BASE + k];
    for (int k = 0; k < R_WORDS - 1; k++) s = s + mem[R_BASE + k];
    ok = !CSUM || (s == mem[R_BASE + R_WORDS - 1]);
    if (ok) begin
      exp_cnt  = exp_cnt + 16'd1;
      exp_data = f;
    end
    exp_r1_q.push_back({!ok, exp_cnt, exp_data});
    exp_r3_q.push_back({!ok, exp_cnt, exp_data});
  endtask

  task automatic pulse_en();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic run_read(input int max);
    push_read();
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (exp_r1_q.size() == 0 && exp_r3_q.size() == 0) break;
      @(negedge clk);
    end
    check("read_drain", 32'(exp_r1_q.size() + exp_r3_q.size()), 32'd0);
  endtask

  task automatic wait_w_state(input logic [1:0] s, input int max, input string nm);
    for (int i = 0; i < max; i++) begin
      if (u1_w_state == s) break;
      @(negedge clk);
    end
    check(nm, 32'(u1_w_state), 32'(s));
  endtask

  task automatic wait_r_addr(input logic [ADDR_W-1:0] a, input int max);
    for (int i = 0; i < max; i++) begin
      if (u1_r_addr == a) break;
      @(negedge clk);
    end
    check("wait_r_addr", 32'(u1_r_addr), 32'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; w_ready = 1'b0; r_valid = 1'b0; w_data = '0;
    exp_cnt = '0; exp_data = '0;
    for (int a = 0; a < 512; a++) mem[a] = 16'(a);
    repeat (3) @(negedge clk);
    check("rst_w_state", 32'(u1_w_state), 0);
    check("rst_r_state", 32'(u1_r_state), 0);
    check("rst_w_pins", 32'({u1_w_valid, u1_w_ce, u1_w_addr, u1_w_din}), 0);
    check("rst_r_pins", 32'({u1_r_ce, u1_r_addr, u1_r_upd, u1_r_err}), 0);
    check("rst_cnt", 32'(u1_cnt), 0);
    check_frame("rst_r_data", u1_r_data, '0);
    rst = 1'b0;
    @(negedge clk);

    // Frame of 0x1000+k; ready arrives after the DSP has seen valid for a while.
    set_wdata(16'h1000, 1'b1);
    w_chk = 1'b1;
    pulse_en();
    check("w_enter_write", 32'(u1_w_state), 32'd1);
    check("r_setup_state", 32'(u1_r_state), 32'd1);
    check("r_setup_pins", 32'({u1_r_ce, u1_r_addr}), 32'({1'b1, 9'd129}));
    wait_w_state(2'd2, 60, "w_reach_hold");
    check("w_q_empty1", 32'(exp_w_q.size()), 0);
    for (int i = 0; i < 5; i++) begin
      check("w_valid_hold", 32'(u1_w_valid), 32'd1);
      @(negedge clk);
    end
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    check("w_done_state", 32'(u1_w_state), 32'd3);
    check("w_valid_done", 32'(u1_w_valid), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("w_idle_en0", 32'(u1_w_state), 32'd0);
      @(negedge clk);
    end

    // Entry snapshot only; early ready during WRITE must not shortcut HOLD.
    set_wdata(16'h2000, 1'b1);
    pulse_en();
    w_ready = 1'b1;
    repeat (3) @(negedge clk);
    w_ready = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < W_WORDS; k++) w_data[16*k +: 16] = 16'hDEAD;
    wait_w_state(2'd2, 60, "w_reach_hold2");
    check("w_q_empty2", 32'(exp_w_q.size()), 0);
    for (int i = 0; i < 3; i++) begin
      check("w_valid_hold2", 32'(u1_w_valid), 32'd1);
      @(negedge clk);
    end
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    wait_w_state(2'd0, 5, "w_back_idle");
    w_chk = 1'b0;

    // RAM word = address; both latencies.
    run_read(200);
    check("r_idle_after", 32'(u1_r_state), 0);
    check("cnt_lat1_a", 32'(u1_cnt), 32'(exp_cnt));
    check("cnt_lat3_a", 32'(u3_cnt), 32'(exp_cnt));

    // Reset mid-read: no partial commit, everything cleared.
    for (int a = 0; a < 512; a++) mem[a] = 16'(a) ^ 16'h5A00;
    pulse_en();
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
    wait_r_addr(9'(R_BASE + 20), 60);
    check_frame("r_data_kept_lat1", u1_r_data, exp_data);
    check_frame("r_data_kept_lat3", u3_r_data, exp_data);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_states", 32'({u1_w_state, u1_r_state}), 0);
    check("mid_rst_w_pins", 32'({u1_w_valid, u1_w_ce, u1_w_addr, u1_w_din}), 0);
    check("mid_rst_r_pins", 32'({u1_r_ce, u1_r_addr, u1_r_upd, u1_r_err, u1_cnt}), 0);
    check_frame("mid_rst_r_data", u1_r_data, '0);
    check_frame("mid_rst_r_data3", u3_r_data, '0);
    rst = 1'b0;
    exp_cnt = '0;
    exp_data = '0;
    repeat (60) @(negedge clk);

    // Counter wrap with a frame carrying a valid checksum.
    for (int k = 0; k < R_WORDS - 1; k++) mem[R_BASE + k] = 16'(k * 256 + 3);
    mem[R_BASE + R_WORDS - 1] = '0;
    for (int k = 0; k < R_WORDS - 1; k++)
      mem[R_BASE + R_WORDS - 1] = mem[R_BASE + R_WORDS - 1] + mem[R_BASE + k];
    force u_dut1.o_frame_cnt = 16'hFFFF;
    force u_dut3.o_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release u_dut1.o_frame_cnt;
    release u_dut3.o_frame_cnt;
    exp_cnt = 16'hFFFF;
    pulse_en();
    run_read(200);
    check("cnt_wrap_lat1", 32'(u1_cnt), 32'(exp_cnt));
    check("cnt_wrap_lat3", 32'(u3_cnt), 32'(exp_cnt));

    // Corrupted checksum word, then the correct one.
    mem[R_BASE + R_WORDS - 1] = mem[R_BASE + R_WORDS - 1] + 16'd1;
    pulse_en();
    run_read(200);
    check("cnt_bad_sum", 32'(u1_cnt), 32'(exp_cnt));
    check_frame("r_data_bad_sum", u1_r_data, exp_data);
    mem[R_BASE + R_WORDS - 1] = mem[R_BASE + R_WORDS - 1] - 16'd1;
    pulse_en();
    run_read(200);
    check("cnt_good_sum", 32'(u1_cnt), 32'(exp_cnt));
    check_frame("r_data_good_sum", u3_r_data, exp_data);

    repeat (5) @(negedge clk);
    check("final_queues", 32'(exp_w_q.size() + exp_r1_q.size() + exp_r3_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
